mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 44 ++++
 rtl/mem_access_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Data-memory bus between the MEM-stage access controller and the data memory.
//
// Signals:
//   dmem_req_o    request, held high until acknowledged       (controller -> mem)
//   dmem_we_o     1 = write, 0 = read, valid while requesting (controller -> mem)
//   dmem_addr_o   word-aligned byte address, [1:0] = 00       (controller -> mem)
//   dmem_wdata_o  store data replicated across byte lanes     (controller -> mem)
//   dmem_be_o     byte-lane enables                           (controller -> mem)
//   dmem_rdata_i  read data, valid on the acknowledge cycle   (mem -> controller)
//   dmem_ack_i    access complete, one-cycle pulse            (mem -> controller)
//
// Modports: master = access controller, slave = data memory.
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_wdata_o,
    output dmem_be_o,
    input  dmem_rdata_i,
    input  dmem_ack_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_wdata_o,
    input  dmem_be_o,
    output dmem_rdata_i,
    output dmem_ack_i
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// MEM stage of a five-stage RISC-V pipeline: issues load/store requests to a
// handshaked data memory, stalls the front of the pipeline until the memory
// acknowledges, extends load data and owns the MEM/WB pipeline register.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   w_data_i             ALU result from EX/MEM (byte address for loads/stores)
//   store_data_i         rs2 value for stores
//   funct3_i             access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//                        (any other code behaves as W)
//   MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i, rd_i   EX/MEM control
//   dmem                 data-memory bus (mem_access_ctrl_if.master)
//   stall_o              freezes PC, IF/ID, ID/EX and EX/MEM while high
//   wb_data_o, rd_o, RegWrite_o   registered MEM/WB outputs
//   misalign_o           registered misaligned-access flag
//
// Build option: define MISALIGN_CHECK_EN to trap misaligned H/W accesses
// (no request, no stall, misalign_o pulsed, write-back suppressed). Without
// it misalign_o is tied low, H uses addr[1] only and W ignores addr[1:0].
//
// The EX/MEM register is frozen while stall_o is high, so the control inputs,
// funct3_i and the low address bits are still valid on the acknowledge cycle
// and are used directly for load extension and write-back.
// -----------------------------------------------------------------------------
module mem_access_ctrl (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              w_data_i,
  input  logic [31:0]              store_data_i,
  input  logic [2:0]               funct3_i,
  input  logic                     MemRead_i,
  input  logic                     MemWrite_i,
  input  logic                     MemtoReg_i,
  input  logic                     RegWrite_i,
  input  logic [4:0]               rd_i,
  mem_access_ctrl_if.master        dmem,
  output logic                     stall_o,
  output logic [31:0]              wb_data_o,
  output logic [4:0]               rd_o,
  output logic                     RegWrite_o,
  output logic                     misalign_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size from funct3; unlisted codes fall back to a word.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_of = SZ_B;
      F3_H, F3_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

  // Byte-lane enables; a halfword only looks at addr[1] for its lane pair.
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    be_of = 4'b0001 << lo;
      SZ_H:    be_of = 4'b0011 << {lo[1], 1'b0};
      default: be_of = 4'b1111;
    endcase
  endfunction

  // Store data replicated so every enabled lane sees the right byte(s).
  function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] sd);
    case (sz)
      SZ_B:    wdata_of = {4{sd[7:0]}};
      SZ_H:    wdata_of = {2{sd[15:0]}};
      default: wdata_of = sd;
    endcase
  endfunction

  // Lane selection plus sign/zero extension of the returned read word.
  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [1:0]  lo,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lo, 3'b000} +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_BU:   load_ext = {24'h00_0000, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_HU:   load_ext = {16'h0000, h};
      default: load_ext = rdata;
    endcase
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic        access_s;
  logic        misalign_s;
  logic        stall_s;
  logic        start_s;
  logic [1:0]  size_s;

  logic        req_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  be_r;

  logic [31:0] wb_data_r;
  logic [4:0]  rd_r;
  logic        reg_write_r;
  logic        misalign_r;

  assign access_s = MemRead_i | MemWrite_i;
  assign size_s   = size_of(funct3_i);

`ifdef MISALIGN_CHECK_EN
  // Misalignment only matters for a new access being decided in IDLE.
  assign misalign_s = (state_r == ST_IDLE) && access_s &&
                      (((size_s == SZ_H) && w_data_i[0]) ||
                       ((size_s == SZ_W) && (w_data_i[1:0] != 2'b00)));
`else
  assign misalign_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state, stall and request-launch decode.
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b0;
    start_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // dmem_ack_i is deliberately not looked at here.
        if (access_s && !misalign_s) begin
          stall_s      = 1'b1;
          start_s      = 1'b1;
          next_state_s = ST_BUSY;
        end else begin
          stall_s      = 1'b0;
          start_s      = 1'b0;
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dmem.dmem_ack_i) begin
          stall_s      = 1'b0;
          next_state_s = ST_IDLE;
        end else begin
          stall_s      = 1'b1;
          next_state_s = ST_BUSY;
        end
      end
      default: begin
        stall_s      = 1'b0;
        start_s      = 1'b0;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Stall is combinational so the pipeline freezes in the same cycle; it is
  // forced low while reset is asserted.
  assign stall_o = stall_s & ~rst_i;

  // Request register: captured on launch, held through BUSY, dropped on ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      be_r    <= 4'b0000;
    end else if (start_s) begin
      req_r   <= 1'b1;
      we_r    <= MemWrite_i;   // read+write together resolves to a write
      addr_r  <= {w_data_i[31:2], 2'b00};
      wdata_r <= wdata_of(size_s, store_data_i);
      be_r    <= be_of(size_s, w_data_i[1:0]);
    end else if ((state_r == ST_BUSY) && dmem.dmem_ack_i) begin
      req_r   <= 1'b0;
    end else begin
      req_r   <= req_r;
    end
  end

  assign dmem.dmem_req_o   = req_r;
  assign dmem.dmem_we_o    = we_r;
  assign dmem.dmem_addr_o  = addr_r;
  assign dmem.dmem_wdata_o = wdata_r;
  assign dmem.dmem_be_o    = be_r;

  // MEM/WB register: a bubble on every stalled edge, otherwise the result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_data_r   <= 32'h0000_0000;
      rd_r        <= 5'd0;
      reg_write_r <= 1'b0;
      misalign_r  <= 1'b0;
    end else if (stall_s) begin
      wb_data_r   <= 32'h0000_0000;
      rd_r        <= 5'd0;
      reg_write_r <= 1'b0;
      misalign_r  <= 1'b0;
    end else begin
      wb_data_r   <= MemtoReg_i ? load_ext(funct3_i, w_data_i[1:0], dmem.dmem_rdata_i)
                                : w_data_i;
      rd_r        <= rd_i;
      reg_write_r <= RegWrite_i & ~misalign_s;
      misalign_r  <= misalign_s;
    end
  end

  assign wb_data_o  = wb_data_r;
  assign rd_o       = rd_r;
  assign RegWrite_o = reg_write_r;
  assign misalign_o = misalign_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed, table-driven bench for mem_access_ctrl. Single-acknowledge
// accesses and non-memory instructions come from a vector table; delayed
// acknowledge, acknowledge in IDLE, reset during BUSY and the misaligned
// access case are written out by hand.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] w_data;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic [4:0]  rd;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        misalign;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .w_data_i     (w_data),
    .store_data_i (store_data),
    .funct3_i     (funct3),
    .MemRead_i    (mem_read),
    .MemWrite_i   (mem_write),
    .MemtoReg_i   (mem_to_reg),
    .RegWrite_i   (reg_write),
    .rd_i         (rd),
    .dmem         (bus),
    .stall_o      (stall),
    .wb_data_o    (wb_data),
    .rd_o         (rd_out),
    .RegWrite_o   (reg_write_out),
    .misalign_o   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w_data;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
    logic        exp_reg_write;
  } vec_t;

  vec_t vecs [12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    w_data     = v.w_data;
    store_data = v.store_data;
    funct3     = v.funct3;
    mem_read   = v.mem_read;
    mem_write  = v.mem_write;
    mem_to_reg = v.mem_to_reg;
    reg_write  = v.reg_write;
    rd         = v.rd;
  endtask

  // One instruction through MEM; memory accesses get ack on the first BUSY cycle.
  task automatic run_vec(input int idx, input vec_t v);
    logic acc;
    acc = v.mem_read | v.mem_write;
    drive(v);
    bus.dmem_ack_i   = 1'b0;
    bus.dmem_rdata_i = 32'h0000_0000;
    #1;
    chk($sformatf("v%0d_stall_issue", idx), {31'd0, stall}, {31'd0, acc});
    tick();
    if (acc) begin
      chk($sformatf("v%0d_req", idx), {31'd0, bus.dmem_req_o}, 32'd1);
      chk($sformatf("v%0d_we", idx), {31'd0, bus.dmem_we_o}, {31'd0, v.mem_write});
      chk($sformatf("v%0d_addr", idx), bus.dmem_addr_o, {v.w_data[31:2], 2'b00});
      chk($sformatf("v%0d_be", idx), {28'd0, bus.dmem_be_o}, {28'd0, v.exp_be});
      chk($sformatf("v%0d_wdata", idx), bus.dmem_wdata_o, v.exp_wdata);
      chk($sformatf("v%0d_busy_stall", idx), {31'd0, stall}, 32'd1);
      chk($sformatf("v%0d_bubble_rw", idx), {31'd0, reg_write_out}, 32'd0);
      chk($sformatf("v%0d_bubble_rd", idx), {27'd0, rd_out}, 32'd0);
      bus.dmem_ack_i   = 1'b1;
      bus.dmem_rdata_i = v.rdata;
      #1;
      chk($sformatf("v%0d_ack_stall", idx), {31'd0, stall}, 32'd0);
      tick();
      bus.dmem_ack_i   = 1'b0;
      bus.dmem_rdata_i = 32'h0000_0000;
      chk($sformatf("v%0d_req_drop", idx), {31'd0, bus.dmem_req_o}, 32'd0);
    end
    chk($sformatf("v%0d_wb_data", idx), wb_data, v.exp_wb);
    chk($sformatf("v%0d_rd", idx), {27'd0, rd_out}, {27'd0, v.rd});
    chk($sformatf("v%0d_regwrite", idx), {31'd0, reg_write_out}, {31'd0, v.exp_reg_write});
    chk($sformatf("v%0d_misalign", idx), {31'd0, misalign}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n_stall;
    bit   done;

    //          w_data        store_data    f3      rd wr m2r rw  rd     rdata         be       wdata         wb            rw
    vecs[0]  = '{32'h0000_0100, 32'h0000_0000, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
    vecs[1]  = '{32'h0000_0103, 32'hAABB_CCDD, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6,  32'h8012_3456, 4'b1000, 32'hDDDD_DDDD, 32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{32'h0000_0103, 32'hAABB_CCDD, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7,  32'h8012_3456, 4'b1000, 32'hDDDD_DDDD, 32'h0000_0080, 1'b1};
    vecs[3]  = '{32'h0000_0102, 32'h0000_0000, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  32'h8001_7FFF, 4'b1100, 32'h0000_0000, 32'hFFFF_8001, 1'b1};
    vecs[4]  = '{32'h0000_0100, 32'h0000_BEEF, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  32'h8001_F00F, 4'b0011, 32'hBEEF_BEEF, 32'h0000_F00F, 1'b1};
    vecs[5]  = '{32'h0000_0202, 32'h0000_1234, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 4'b1100, 32'h1234_1234, 32'h0000_0202, 1'b0};
    vecs[6]  = '{32'h0000_0201, 32'h0000_00A5, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0201, 1'b0};
    vecs[7]  = '{32'h0000_0055, 32'h0000_0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0055, 1'b1};
    vecs[8]  = '{32'h0000_0101, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h0000_7F00, 4'b0010, 32'h0000_0000, 32'h0000_007F, 1'b1};
    vecs[9]  = '{32'h0000_0104, 32'h1122_3344, 3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h1234_5678, 4'b1111, 32'h1122_3344, 32'h1234_5678, 1'b1};
    vecs[10] = '{32'h0000_0300, 32'hCAFE_F00D, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  32'hFFFF_FFFF, 4'b1111, 32'hCAFE_F00D, 32'h0000_0300, 1'b1};
    vecs[11] = '{32'hFFFF_FFFF, 32'h0000_0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    // Reset with a store pending on the inputs: everything must read zero.
    rst = 1'b1;
    bus.dmem_ack_i   = 1'b0;
    bus.dmem_rdata_i = 32'h0000_0000;
    v = vecs[5];
    drive(v);
    reg_write = 1'b1;
    rd        = 5'd4;
    tick();
    tick();
    chk("rst_req",      {31'd0, bus.dmem_req_o}, 32'd0);
    chk("rst_we",       {31'd0, bus.dmem_we_o}, 32'd0);
    chk("rst_addr",     bus.dmem_addr_o, 32'd0);
    chk("rst_wdata",    bus.dmem_wdata_o, 32'd0);
    chk("rst_be",       {28'd0, bus.dmem_be_o}, 32'd0);
    chk("rst_stall",    {31'd0, stall}, 32'd0);
    chk("rst_wb_data",  wb_data, 32'd0);
    chk("rst_rd",       {27'd0, rd_out}, 32'd0);
    chk("rst_regwrite", {31'd0, reg_write_out}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    v = vecs[11];
    drive(v);
    rst = 1'b0;

    // Vector table; entry 7 (ADD) directly precedes a load in entry 8.
    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
    end

    // LB 0x103 with ack on the fourth BUSY cycle: four stall cycles.
    v = vecs[1];
    v.rd = 5'd4;
    drive(v);
    n_stall = 0;
    done    = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      bus.dmem_ack_i   = (c == 4);
      bus.dmem_rdata_i = (c == 4) ? 32'h80AB_CDEF : 32'h0000_0000;
      #1;
      if (c > 0) begin
        chk("lbd_req_held",  {31'd0, bus.dmem_req_o}, 32'd1);
        chk("lbd_addr_held", bus.dmem_addr_o, 32'h0000_0100);
        chk("lbd_bubble",    {31'd0, reg_write_out}, 32'd0);
      end
      if (stall) n_stall++;
      else       done = 1'b1;
      tick();
    end
    bus.dmem_ack_i = 1'b0;
    chk("lbd_stall_cycles", n_stall, 32'd4);
    chk("lbd_wb_data",  wb_data, 32'hFFFF_FF80);
    chk("lbd_regwrite", {31'd0, reg_write_out}, 32'd1);
    chk("lbd_rd",       {27'd0, rd_out}, 32'd4);

    // Ack in IDLE: ignored for a non-memory op and for a pending load.
    v = vecs[7];
    v.w_data = 32'h0000_0099;
    v.rd     = 5'd2;
    drive(v);
    bus.dmem_ack_i = 1'b1;
    #1;
    chk("idle_ack_alu_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("idle_ack_alu_req", {31'd0, bus.dmem_req_o}, 32'd0);
    chk("idle_ack_alu_wb",  wb_data, 32'h0000_0099);
    v = vecs[0];
    v.w_data = 32'h0000_0500;
    drive(v);
    #1;
    chk("idle_ack_ld_stall", {31'd0, stall}, 32'd1);
    tick();
    bus.dmem_ack_i = 1'b0;
    chk("idle_ack_ld_req",    {31'd0, bus.dmem_req_o}, 32'd1);
    chk("idle_ack_ld_bubble", {31'd0, reg_write_out}, 32'd0);
    bus.dmem_ack_i   = 1'b1;
    bus.dmem_rdata_i = 32'h0000_0001;
    tick();
    bus.dmem_ack_i = 1'b0;
    chk("idle_ack_ld_wb", wb_data, 32'h0000_0001);

    // Reset mid-BUSY aborts the access; a later ack causes no write-back.
    v = vecs[0];
    v.w_data = 32'h0000_0400;
    v.rd     = 5'd9;
    drive(v);
    tick();
    chk("rbusy_req_before", {31'd0, bus.dmem_req_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rbusy_req_async", {31'd0, bus.dmem_req_o}, 32'd0);
    chk("rbusy_stall",     {31'd0, stall}, 32'd0);
    chk("rbusy_addr",      bus.dmem_addr_o, 32'd0);
    v = vecs[11];
    v.w_data = 32'h0000_0077;
    drive(v);
    tick();
    rst = 1'b0;
    #1;
    chk("rbusy_idle_no_stall", {31'd0, stall}, 32'd0);
    bus.dmem_ack_i   = 1'b1;
    bus.dmem_rdata_i = 32'h0000_0BAD;
    tick();
    bus.dmem_ack_i = 1'b0;
    chk("rbusy_late_ack_req", {31'd0, bus.dmem_req_o}, 32'd0);
    chk("rbusy_no_wb",        {31'd0, reg_write_out}, 32'd0);
    chk("rbusy_wb_data",      wb_data, 32'h0000_0077);

`ifdef MISALIGN_CHECK_EN
    // LW 0x101 is trapped: no request, no stall, one-cycle misalign flag.
    v = vecs[0];
    v.w_data = 32'h0000_0101;
    drive(v);
    #1;
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("mis_req",      {31'd0, bus.dmem_req_o}, 32'd0);
    chk("mis_flag",     {31'd0, misalign}, 32'd1);
    chk("mis_regwrite", {31'd0, reg_write_out}, 32'd0);
    v = vecs[7];
    drive(v);
    tick();
    chk("mis_flag_clear", {31'd0, misalign}, 32'd0);
    chk("mis_next_wb",    wb_data, 32'h0000_0055);
`else
    // Without the check, LH 0x103 uses addr[1] only and LW 0x101 is a word.
    v = vecs[3];
    v.w_data = 32'h0000_0103;
    v.rdata  = 32'hFFEE_0011;
    v.exp_wb = 32'hFFFF_FFEE;
    run_vec(20, v);
    v = vecs[0];
    v.w_data = 32'h0000_0101;
    run_vec(21, v);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
